// File: rtl/load_store_unit_if.sv
// Request/response and data_mem bus for the load/store unit.
// The slave modport is the LSU; the master modport is the execute stage plus data_mem.
interface load_store_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_data;
    logic [DATA_W-1:0] dm_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
        input  dm_rdata, rsp_ready,
        output req_ready, dm_we, dm_addr, dm_data, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
        output dm_rdata, rsp_ready,
        input  req_ready, dm_we, dm_addr, dm_data, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store at a time, byte/half/word with extension on loads
// and read-modify-write for sub-word stores; bad requests answer with rsp_err and never touch memory.
module load_store_unit #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    load_store_unit_if.slave    lsu
);
    localparam int unsigned BYTE_AW = ADDR_W + 2;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_WRITE, S_RESP} state_e;

    state_e            state_q, state_d;
    logic              store_q, store_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [1:0]        lane_q, lane_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              dm_we_q, dm_we_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0] dm_data_q, dm_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [ADDR_W-1:0] req_waddr_c;
    logic              req_err_c;
    logic [7:0]        rd_byte_c;
    logic [15:0]       rd_half_c;
    logic [DATA_W-1:0] load_res_c;
    logic [DATA_W-1:0] merged_c;

    // Request legality: size, alignment and implemented range.
    always_comb begin
        req_waddr_c = lsu.req_addr[BYTE_AW-1:2];
        req_err_c   = 1'b0;
        case (lsu.req_size)
            2'b00:   req_err_c = 1'b0;
            2'b01:   req_err_c = lsu.req_addr[0];
            2'b10:   req_err_c = |lsu.req_addr[1:0];
            default: req_err_c = 1'b1;
        endcase
        if ({1'b0, req_waddr_c} >= (ADDR_W+1)'(MEM_DEPTH)) req_err_c = 1'b1;
    end

    // Lane select/extend for loads and lane merge for sub-word stores.
    always_comb begin
        rd_byte_c = lsu.dm_rdata[{lane_q, 3'b000} +: 8];
        rd_half_c = lsu.dm_rdata[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_res_c = {{(DATA_W-8){signed_q & rd_byte_c[7]}}, rd_byte_c};
            2'b01:   load_res_c = {{(DATA_W-16){signed_q & rd_half_c[15]}}, rd_half_c};
            default: load_res_c = lsu.dm_rdata;
        endcase
        merged_c = lsu.dm_rdata;
        if (size_q == 2'b00) merged_c[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else                 merged_c[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        size_d     = size_q;
        signed_d   = signed_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        dm_addr_d  = dm_addr_q;
        dm_data_d  = dm_data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (lsu.req_valid && req_ready_q) begin
                    store_d    = lsu.req_store;
                    size_d     = lsu.req_size;
                    signed_d   = lsu.req_signed;
                    lane_d     = lsu.req_addr[1:0];
                    wdata_d    = lsu.req_wdata;
                    rsp_data_d = '0;
                    rsp_err_d  = req_err_c;
                    if (req_err_c) begin
                        state_d = S_RESP;
                    end else if (lsu.req_store && lsu.req_size == 2'b10) begin
                        state_d   = S_WRITE;
                        dm_addr_d = req_waddr_c;
                        dm_data_d = lsu.req_wdata;
                    end else begin
                        state_d   = S_READ;
                        dm_addr_d = req_waddr_c;
                    end
                end
            end
            S_READ:  state_d = S_CAPT;
            S_CAPT: begin
                if (store_q) begin
                    state_d   = S_WRITE;
                    dm_data_d = merged_c;
                end else begin
                    state_d    = S_RESP;
                    rsp_data_d = load_res_c;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  if (lsu.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
        dm_we_d     = (state_d == S_WRITE);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_data_q   <= dm_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign lsu.req_ready = req_ready_q;
    assign lsu.dm_we     = dm_we_q;
    assign lsu.dm_addr   = dm_addr_q;
    assign lsu.dm_data   = dm_data_q;
    assign lsu.rsp_valid = rsp_valid_q;
    assign lsu.rsp_data  = rsp_data_q;
    assign lsu.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of request vectors with expected result,
// error flag, latency and write count, plus hand-written reset and backpressure sequences.
module tb_load_store_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    load_store_unit_if #(.DATA_W(32), .ADDR_W(12)) bus ();

    load_store_unit #(.DATA_W(32), .ADDR_W(12), .MEM_DEPTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsu   (bus.slave)
    );

    logic [31:0] mem [32] = '{default: 32'h0};

    // data_mem model: registered read, write on dm_we.
    always @(posedge clk) begin
        if (bus.dm_we) begin
            checks++;
            if (bus.dm_addr >= 12'd32) begin
                errors++;
                $display("FAIL dm_we_range: got addr %0d required < 32", bus.dm_addr);
            end
            mem[bus.dm_addr[4:0]] <= bus.dm_data;
        end
        bus.dm_rdata <= mem[bus.dm_addr[4:0]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st;
        logic [1:0]  sz;
        logic        sg;
        logic [13:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic st, input logic [1:0] sz, input logic sg,
                       input logic [13:0] addr, input logic [31:0] wd, input logic [31:0] ed,
                       input logic ee, input int el, input int ew);
        vec_t v;
        v.name = nm; v.st = st; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd;
        v.exp_data = ed; v.exp_err = ee; v.exp_lat = el; v.exp_we = ew;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, got, exp);
        end
    endtask

    // Issue one request with rsp_ready=1; report latency (cycles after handshake) and writes.
    task automatic run_req(input logic st, input logic [1:0] sz, input logic sg,
                           input logic [13:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] data, output logic err,
                           output int we_cnt);
        int n;
        n = 0;
        bus.req_store  = st;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("req_ready_wait", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = 14'($urandom);
        bus.req_wdata  = $urandom;
        lat = 1;
        we_cnt = 0;
        while (!bus.rsp_valid && lat < 20) begin
            if (bus.dm_we) we_cnt++;
            @(posedge clk); #1; lat++;
        end
        check("rsp_valid_wait", 32'(bus.rsp_valid), 32'd1);
        data = bus.rsp_data;
        err  = bus.rsp_err;
        @(posedge clk); #1;
    endtask

    int          lat;
    int          wec;
    logic [31:0] rd;
    logic        re;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        // Vector table: name, store, size, signed, addr, wdata, data, err, latency, writes.
        add("st_w_004",      1, 2'b10, 0, 14'h004, 32'h0000_0D1F, 32'h0,          0, 2, 1);
        add("ld_w_004",      0, 2'b10, 0, 14'h004, 32'h0,         32'h0000_0D1F,  0, 3, 0);
        add("st_w_008",      1, 2'b10, 0, 14'h008, 32'h1234_80FF, 32'h0,          0, 2, 1);
        add("ld_b_008_s",    0, 2'b00, 1, 14'h008, 32'h0,         32'hFFFF_FFFF,  0, 3, 0);
        add("ld_b_009_u",    0, 2'b00, 0, 14'h009, 32'h0,         32'h0000_0080,  0, 3, 0);
        add("ld_h_00a_s",    0, 2'b01, 1, 14'h00A, 32'h0,         32'h0000_1234,  0, 3, 0);
        add("ld_h_008_s",    0, 2'b01, 1, 14'h008, 32'h0,         32'hFFFF_80FF,  0, 3, 0);
        add("ld_h_008_u",    0, 2'b01, 0, 14'h008, 32'h0,         32'h0000_80FF,  0, 3, 0);
        add("st_w_00c",      1, 2'b10, 0, 14'h00C, 32'hAABB_CCDD, 32'h0,          0, 2, 1);
        add("st_b_00e",      1, 2'b00, 0, 14'h00E, 32'hFFFF_FF5A, 32'h0,          0, 4, 1);
        add("ld_w_00c_a",    0, 2'b10, 0, 14'h00C, 32'h0,         32'hAA5A_CCDD,  0, 3, 0);
        add("st_h_00c",      1, 2'b01, 0, 14'h00C, 32'hABCD_1000, 32'h0,          0, 4, 1);
        add("ld_w_00c_b",    0, 2'b10, 0, 14'h00C, 32'h0,         32'hAA5A_1000,  0, 3, 0);
        add("ld_b_00f_u",    0, 2'b00, 0, 14'h00F, 32'h0,         32'h0000_00AA,  0, 3, 0);
        add("ld_b_00f_s",    0, 2'b00, 1, 14'h00F, 32'h0,         32'hFFFF_FFAA,  0, 3, 0);
        add("err_ld_h_001",  0, 2'b01, 1, 14'h001, 32'h0,         32'h0,          1, 1, 0);
        add("err_st_w_002",  1, 2'b10, 0, 14'h002, 32'hFFFF_FFFF, 32'h0,          1, 1, 0);
        add("err_size3",     0, 2'b11, 0, 14'h010, 32'h0,         32'h0,          1, 1, 0);
        add("err_ld_w_080",  0, 2'b10, 0, 14'h080, 32'h0,         32'h0,          1, 1, 0);
        add("err_st_b_080",  1, 2'b00, 0, 14'h081, 32'h0000_0011, 32'h0,          1, 1, 0);
        add("ld_w_000_clean",0, 2'b10, 0, 14'h000, 32'h0,         32'h0,          0, 3, 0);
        add("ld_w_004_clean",0, 2'b10, 0, 14'h004, 32'h0,         32'h0000_0D1F,  0, 3, 0);
        add("st_w_07c_top",  1, 2'b10, 0, 14'h07C, 32'hDEAD_BEEF, 32'h0,          0, 2, 1);
        add("st_b_07c",      1, 2'b00, 0, 14'h07C, 32'h0000_0077, 32'h0,          0, 4, 1);
        add("ld_h_07e_u",    0, 2'b01, 0, 14'h07E, 32'h0,         32'h0000_DEAD,  0, 3, 0);
        add("ld_w_07c",      0, 2'b10, 0, 14'h07C, 32'h0,         32'hDEAD_BE77,  0, 3, 0);

        // Reset values while held in reset.
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_dm_we",     32'(bus.dm_we),     32'd0);
        check("rst_dm_addr",   32'(bus.dm_addr),   32'd0);
        check("rst_rsp_data",  bus.rsp_data,       32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_req_ready", 32'(bus.req_ready), 32'd1);

        foreach (vecs[i]) begin
            run_req(vecs[i].st, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd, lat, rd, re, wec);
            check({vecs[i].name, "_data"}, rd, vecs[i].exp_data);
            check({vecs[i].name, "_err"},  32'(re), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_lat"},  32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_we"},   32'(wec), 32'(vecs[i].exp_we));
            check({vecs[i].name, "_exit"}, 32'(bus.rsp_valid), 32'd0);
        end

        // Backpressure: load held in RESP, a second request waiting behind it.
        bus.rsp_ready  = 1'b0;
        bus.req_store  = 1'b0; bus.req_size = 2'b10; bus.req_signed = 1'b0;
        bus.req_addr   = 14'h008; bus.req_wdata = 32'h0;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_size   = 2'b00; bus.req_addr = 14'h009;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("bp_lat", 32'(lat), 32'd3);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_data",  bus.rsp_data,       32'h1234_80FF);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_exit_valid", 32'(bus.rsp_valid), 32'd0);
        check("bp_exit_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("b2b_read_addr", 32'(bus.dm_addr), 32'd2);
        check("b2b_read_we",   32'(bus.dm_we),   32'd0);
        check("b2b_ready_low", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b2b_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b_rsp_data",  bus.rsp_data,       32'h0000_0080);
        @(posedge clk); #1;

        // Reset during WRITE aborts the store and suppresses the response.
        bus.req_store = 1'b1; bus.req_size = 2'b10; bus.req_signed = 1'b0;
        bus.req_addr  = 14'h010; bus.req_wdata = 32'h0000_0055;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("mid_write_we", 32'(bus.dm_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_we",        32'(bus.dm_we),     32'd0);
        check("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("async_rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        run_req(1'b0, 2'b10, 1'b0, 14'h010, 32'h0, lat, rd, re, wec);
        check("aborted_store_data", rd, 32'h0);
        check("aborted_store_lat",  32'(lat), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
